// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock-enable/divider.
package prog_clk_div_pkg;

    // A half-period of zero parks a channel with its output held low.
    localparam int HALF_OFF = 0;

    // What a channel does in a given cycle, in priority order.
    typedef enum logic [1:0] {
        MODE_SYNC,
        MODE_OFF,
        MODE_HOLD,
        MODE_RUN
    } chan_mode_e;

    // Width needed to address n channels; never less than one bit.
    function automatic int ch_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active and shadow half-period,
// pending-update flag, square-wave output and edge tick.
module clk_div_chan
    import prog_clk_div_pkg::*;
#(
    parameter int CNT_W    = 26,
    parameter int DEF_HALF = 25_000_000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] OFF_H = CNT_W'(HALF_OFF);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] half_reg, half_next;
    logic [CNT_W-1:0] shadow_reg, shadow_next;
    logic             pend_reg, pend_next;
    logic             out_reg, out_next;
    logic             tick_reg, tick_next;

    logic [CNT_W-1:0] eff_shadow;
    logic             eff_pend;
    logic             at_wrap;
    chan_mode_e       mode;

    // Fold a same-cycle write into the shadow view and pick this cycle's mode.
    always_comb begin
        eff_shadow = wr ? wr_half : shadow_reg;
        eff_pend   = wr | pend_reg;
        // ">=" rather than "==" so a stale count can never run past H-1.
        at_wrap    = (cnt_reg >= (half_reg - ONE));
        if (sync) begin
            mode = MODE_SYNC;
        end else if (half_reg == OFF_H) begin
            mode = MODE_OFF;
        end else if (!en) begin
            mode = MODE_HOLD;
        end else begin
            mode = MODE_RUN;
        end
    end

    // Next-state: counting, wrapping, and when a pending half-period takes effect.
    always_comb begin
        cnt_next    = cnt_reg;
        half_next   = half_reg;
        shadow_next = eff_shadow;
        pend_next   = eff_pend;
        out_next    = out_reg;
        tick_next   = 1'b0;
        case (mode)
            MODE_SYNC: begin
                cnt_next  = '0;
                out_next  = 1'b0;
                half_next = eff_shadow;
                pend_next = 1'b0;
            end
            MODE_OFF: begin
                cnt_next = '0;
                out_next = 1'b0;
                if (eff_pend) begin
                    half_next = eff_shadow;
                    pend_next = 1'b0;
                end
            end
            MODE_HOLD: begin
                // Output level is frozen; counting restarts from zero on re-enable.
                cnt_next = '0;
                if (eff_pend) begin
                    half_next = eff_shadow;
                    pend_next = 1'b0;
                end
            end
            MODE_RUN: begin
                if (at_wrap) begin
                    cnt_next  = '0;
                    out_next  = ~out_reg;
                    tick_next = 1'b1;
                    if (eff_pend) begin
                        half_next = eff_shadow;
                        pend_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    // Channel state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg    <= '0;
            half_reg   <= DEF_H;
            shadow_reg <= DEF_H;
            pend_reg   <= 1'b0;
            out_reg    <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            half_reg   <= half_next;
            shadow_reg <= shadow_next;
            pend_reg   <= pend_next;
            out_reg    <= out_next;
            tick_reg   <= tick_next;
        end
    end

    assign clk_out = out_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/prog_clk_div.sv
// N-channel programmable clock divider: decodes configuration writes to
// per-channel strobes, flags out-of-range writes, and hosts the channels.
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter  int N_CH     = 3,
    parameter  int CNT_W    = 26,
    parameter  int DEF_HALF = 25_000_000,
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    // One extra bit so N_CH = 2**CH_W is representable in the comparison.
    localparam logic [CH_W:0] N_CH_V = (CH_W + 1)'(N_CH);

    logic ch_valid;
    logic err_reg;

    assign ch_valid = ({1'b0, cfg_ch} < N_CH_V);

    // Out-of-range write produces a single-cycle error pulse one cycle later.
    always_ff @(posedge clk) begin
        if (clr) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= cfg_we & ~ch_valid;
        end
    end

    assign cfg_err = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            logic wr;
            assign wr = cfg_we && (cfg_ch == CH_W'(gi));

            clk_div_chan #(
                .CNT_W    (CNT_W),
                .DEF_HALF (DEF_HALF)
            ) u_chan (
                .clk     (clk),
                .clr     (clr),
                .en      (en[gi]),
                .sync    (sync),
                .wr      (wr),
                .wr_half (cfg_half),
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: an edge-time model checked every cycle, plus
// hand-computed expectations at known edges.
module tb_prog_clk_div;

    localparam int N_CH     = 3;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 4;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              clr;
    logic [N_CH-1:0]   en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_err;
    logic [N_CH-1:0]   clk_out;
    logic [N_CH-1:0]   tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_clk_div #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    // Model: each channel knows the absolute edge number of its next toggle.
    int            n = 0;
    int            m_h   [N_CH];
    int            m_s   [N_CH];
    int            m_due [N_CH];
    bit            m_p   [N_CH];
    logic [N_CH-1:0] m_out  = '0;
    logic [N_CH-1:0] m_tick = '0;
    logic          m_err   = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_restart;

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at edge %0d", name, act, exp, n);
        end
    endtask

    // Model update at every rising edge, from the inputs sampled there.
    initial forever begin
        @(posedge clk);
        n++;
        if (clr) begin
            for (int c = 0; c < N_CH; c++) begin
                m_h[c]    = DEF_HALF;
                m_s[c]    = DEF_HALF;
                m_p[c]    = 1'b0;
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
                m_due[c]  = n + DEF_HALF;
            end
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_err = cfg_we && (int'(cfg_ch) >= N_CH);
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_s[c] = int'(cfg_half);
                    m_p[c] = 1'b1;
                end
                m_tick[c] = 1'b0;
                m_restart = 1'b1;
                if (sync) begin
                    m_out[c] = 1'b0;
                    m_h[c]   = m_s[c];
                    m_p[c]   = 1'b0;
                end else begin
                    if (m_h[c] == 0) begin
                        m_out[c] = 1'b0;
                    end else if (en[c] && n == m_due[c]) begin
                        m_out[c]  = ~m_out[c];
                        m_tick[c] = 1'b1;
                    end else if (en[c]) begin
                        m_restart = 1'b0;
                    end
                    if (m_restart && m_p[c]) begin
                        m_h[c] = m_s[c];
                        m_p[c] = 1'b0;
                    end
                end
                if (m_restart) begin
                    m_due[c] = n + m_h[c];
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check_v("model_clk_out", 32'(clk_out), 32'(m_out));
            check_v("model_tick",    32'(tick),    32'(m_tick));
            check_v("model_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic wait_edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input int half);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_half = CNT_W'(half);
        wait_edges(1);
        cfg_we   = 1'b0;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        clr = 1'b1; en = '0; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        wait_edges(2);
        check_v("reset_clk_out", 32'(clk_out), 32'h0);
        check_v("reset_tick",    32'(tick),    32'h0);
        check_v("reset_cfg_err", 32'(cfg_err), 32'h0);

        // Release reset with all channels enabled: edges at 4, 8, 12.
        en = 3'b111; clr = 1'b0;
        wait_edges(3);
        check_v("rel_e3_out", 32'(clk_out), 32'h0);
        wait_edges(1);
        check_v("rel_e4_out", 32'(clk_out), 32'h7);
        check_v("rel_e4_tick", 32'(tick), 32'h7);
        wait_edges(1);
        check_v("rel_e5_tick", 32'(tick), 32'h0);
        wait_edges(3);
        check_v("rel_e8_out", 32'(clk_out), 32'h0);
        check_v("rel_e8_tick", 32'(tick), 32'h7);
        wait_edges(4);
        check_v("rel_e12_out", 32'(clk_out), 32'h7);

        // Reprogram ch1 to 2 while its count is 1: takes effect at edge 16.
        wait_edges(1);
        cfg_write(1, 2);
        wait_edges(2);
        check_v("rp_e16_out", 32'(clk_out), 32'h0);
        check_v("rp_e16_tick", 32'(tick), 32'h7);
        wait_edges(2);
        check_v("rp_e18_out", 32'(clk_out), 32'h2);
        check_v("rp_e18_tick", 32'(tick), 32'h2);
        wait_edges(2);
        check_v("rp_e20_out", 32'(clk_out), 32'h5);

        // Mis-phase the channels, then sync with a same-cycle write to ch2.
        cfg_write(0, 3);
        wait_edges(2);
        cfg_write(1, 7);
        cfg_write(1, 5);
        wait_edges(15);
        sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd2;
        wait_edges(1);
        sync = 1'b0; cfg_we = 1'b0;
        check_v("sync_out", 32'(clk_out), 32'h0);
        check_v("sync_tick", 32'(tick), 32'h0);
        wait_edges(2);
        check_v("sync_s2_out", 32'(clk_out), 32'h4);
        wait_edges(1);
        check_v("sync_s3_out", 32'(clk_out), 32'h5);
        wait_edges(2);
        check_v("sync_s5_out", 32'(clk_out), 32'h3);
        check_v("sync_s5_tick", 32'(tick), 32'h2);
        wait_edges(7);

        // Turn ch2 off, then bring it back at clk/2.
        cfg_write(2, 0);
        wait_edges(10);
        check_v("off_ch2_out", 32'(clk_out[2]), 32'h0);
        check_v("off_ch2_tick", 32'(tick[2]), 32'h0);
        cfg_write(2, 1);
        check_v("on_w0_ch2_out", 32'(clk_out[2]), 32'h0);
        wait_edges(1);
        check_v("on_w1_ch2_out", 32'(clk_out[2]), 32'h1);
        check_v("on_w1_ch2_tick", 32'(tick[2]), 32'h1);
        wait_edges(1);
        check_v("on_w2_ch2_out", 32'(clk_out[2]), 32'h0);
        check_v("on_w2_ch2_tick", 32'(tick[2]), 32'h1);

        // Out-of-range write: one error pulse, timing untouched.
        cfg_write(3, 9);
        check_v("err_pulse", 32'(cfg_err), 32'h1);
        wait_edges(1);
        check_v("err_clear", 32'(cfg_err), 32'h0);
        wait_edges(12);

        // Hold ch1 for a while, then resume.
        en = 3'b101;
        wait_edges(5);
        en = 3'b111;
        wait_edges(12);

        // Rapid rewrites of ch0 land on assorted phases, including wrap cycles.
        for (int i = 0; i < 8; i++) begin
            cfg_write(0, (i % 2 == 0) ? 2 : 3);
            wait_edges(i % 3);
        end
        wait_edges(12);

        // Clear mid-period, then restart with ch0 disabled.
        clr = 1'b1;
        wait_edges(1);
        check_v("clr_out", 32'(clk_out), 32'h0);
        check_v("clr_tick", 32'(tick), 32'h0);
        check_v("clr_err", 32'(cfg_err), 32'h0);
        clr = 1'b0; en = 3'b110;
        wait_edges(4);
        check_v("clr_e4_out", 32'(clk_out), 32'h6);
        check_v("clr_e4_tick", 32'(tick), 32'h6);
        wait_edges(12);
        check_v("clr_ch0_idle", 32'(clk_out[0]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
